press_sprite_reader: RTL and testbench
======================================

PRESS_SPRITE_READER -- requirements
Module: press_sprite_reader

Interface
REQ-001 SHALL have parameter X0, default 236, meaning the screen column of the sprite's left edge.
REQ-002 SHALL have parameter Y0, default 400, meaning the screen row of the sprite's top edge.
REQ-003 SHALL have parameter SPR_W, default 168, meaning the sprite width in pixels.
REQ-004 SHALL have parameter SPR_H, default 12, meaning the sprite height in pixels; SPR_W*SPR_H SHALL be at most 2016.
REQ-005 SHALL have parameter TRANSP, default 8'h00, meaning the ROM value treated as transparent.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, meaning the number of frames per blink phase (1..255).
REQ-007 SHALL have ports (one clock; reset is asynchronous and active-high):
  i_clk2  in  1  pixel clock, also clocks the ROM.
  i_rst  in  1  async active-high reset.
  i_x  in  10  current pixel column.
  i_y  in  10  current pixel row.
  i_active  in  1  visible-area flag for (i_x,i_y).
  i_frame_tick  in  1  one-cycle pulse, once per frame.
  i_enable  in  1  prompt display request (level).
  o_addr  out  11  address to sprite ROM.
  i_data  in  8  ROM read data, valid one cycle after o_addr.
  o_pixel  out  8  sprite pixel value.
  o_pixel_valid  out  1  o_pixel is opaque and must override background.

Function
REQ-008 SHALL compute in_box = i_active & (X0 <= i_x < X0+SPR_W) & (Y0 <= i_y < Y0+SPR_H), with unsigned comparisons at 10-bit width or wider.
REQ-009 SHALL register o_addr = (i_y-Y0)*SPR_W + (i_x-X0) when in_box, else 0, one cycle after i_x/i_y are presented.
REQ-010 SHALL keep the address arithmetic at 11 bits or wider without truncation, so the maximum is SPR_W*SPR_H-1 (2015 at defaults).
REQ-011 SHALL register in_box together with the blink visibility (vis) at stage 1 and delay both one further cycle to align with i_data.
REQ-012 SHALL output o_pixel = i_data and o_pixel_valid = in_box_d2 & vis_d2 & (i_data != TRANSP), both registered, so that total latency from i_x/i_y to o_pixel is exactly 2 cycles.
REQ-013 SHALL drive o_pixel to 0 whenever o_pixel_valid is 0.
REQ-014 SHALL implement a blink FSM with states IDLE (vis=0), SHOW (vis=1) and HIDE (vis=0), and an 8-bit frame counter fcnt.
REQ-015 SHALL, from IDLE with i_enable=1, go to SHOW with fcnt=0.
REQ-016 SHALL, in SHOW or HIDE on i_frame_tick, increment fcnt; when fcnt==BLINK_FRAMES-1 it SHALL toggle SHOW/HIDE and clear fcnt.
REQ-017 SHALL, from any state with i_enable=0, go to IDLE with fcnt=0 on the next edge; i_enable=0 SHALL take priority over a simultaneous i_frame_tick.
REQ-018 SHALL ignore i_frame_tick in IDLE.
REQ-019 SHALL take vis from the registered FSM state, so a state change affects only pixels presented after the edge.
REQ-020 SHALL, when i_x/i_y move from the last sprite column to the next row, produce a contiguous address sequence with no address skipped or repeated.

Reset
REQ-021 SHALL, while i_rst=1 asynchronously, force state=IDLE, fcnt=0, o_addr=0, o_pixel=0, o_pixel_valid=0 and clear all pipeline flags.
REQ-022 SHALL resume normal operation on the first i_clk2 edge after i_rst deasserts; pixels presented during reset SHALL never produce o_pixel_valid=1.

Verification
REQ-023 Bench SHALL check: enable=1, active=1, (236,400), i_data=8'h3C next cycle -> o_addr=0 after 1 cycle, then o_pixel=8'h3C, valid=1 after 2 cycles.
REQ-024 Bench SHALL check: (403,411) -> o_addr=2015; (404,400) and (235,400) -> o_addr=0, valid=0; (300,412) -> valid=0.
REQ-025 Bench SHALL check: in-box pixel with i_data=8'h00 -> valid=0 and o_pixel=0; same pixel with i_active=0 -> valid=0.
REQ-026 Bench SHALL check: enable=1 then 29 ticks -> still SHOW; 30th tick -> HIDE (valid=0 for an in-box opaque pixel); 30 more ticks -> SHOW.
REQ-027 Bench SHALL check: enable dropped on the same cycle as a tick -> IDLE with fcnt=0; re-enable -> SHOW with a full 30-frame phase.
REQ-028 Bench SHALL check: i_rst pulsed mid-row during SHOW -> all outputs 0 immediately, state IDLE, and the first valid pixel only 2 cycles after the first in-box coordinate following release.

Source files
------------

// File: rtl/press_sprite_reader.sv
`timescale 1ns/1ps
// Press-start prompt sprite reader: maps screen coordinates to sprite ROM addresses
// and gates the returned pixel with a blinking visibility FSM (2-cycle latency).
module press_sprite_reader #(
    parameter int          X0           = 236,
    parameter int          Y0           = 400,
    parameter int          SPR_W        = 168,
    parameter int          SPR_H        = 12,
    parameter logic [7:0]  TRANSP       = 8'h00,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        i_clk2,
    input  logic        i_rst,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_active,
    input  logic        i_frame_tick,
    input  logic        i_enable,
    output logic [10:0] o_addr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_pixel,
    output logic        o_pixel_valid
);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  SHOW  = 2'd1;
    localparam logic [1:0]  HIDE  = 2'd2;
    localparam logic [10:0] X_LO  = 11'(X0);
    localparam logic [10:0] X_HI  = 11'(X0 + SPR_W);
    localparam logic [10:0] Y_LO  = 11'(Y0);
    localparam logic [10:0] Y_HI  = 11'(Y0 + SPR_H);
    localparam logic [10:0] W11   = 11'(SPR_W);
    localparam logic [7:0]  FLAST = 8'(BLINK_FRAMES - 1);

    logic [1:0]  state;
    logic [7:0]  fcnt;
    logic [10:0] x11, y11, rel_x, rel_y, addr_c;
    logic        in_box, box_d1, vis_d1;

    // Widen to 11 bits so the box edge compares cannot wrap at 10 bits.
    assign x11    = {1'b0, i_x};
    assign y11    = {1'b0, i_y};
    assign in_box = i_active && (x11 >= X_LO) && (x11 < X_HI) &&
                    (y11 >= Y_LO) && (y11 < Y_HI);
    assign rel_x  = x11 - X_LO;
    assign rel_y  = y11 - Y_LO;
    assign addr_c = rel_y * W11 + rel_x;

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            fcnt  <= '0;
        end else if (!i_enable) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= SHOW;
                    fcnt  <= '0;
                end
                SHOW, HIDE: begin
                    if (i_frame_tick) begin
                        if (fcnt == FLAST) begin
                            state <= (state == SHOW) ? HIDE : SHOW;
                            fcnt  <= '0;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    // Stage 1 registers address, box and visibility; stage 2 meets the ROM data.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            o_addr        <= '0;
            box_d1        <= 1'b0;
            vis_d1        <= 1'b0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
        end else begin
            o_addr <= in_box ? addr_c : 11'd0;
            box_d1 <= in_box;
            vis_d1 <= (state == SHOW);
            if (box_d1 && vis_d1 && (i_data != TRANSP)) begin
                o_pixel       <= i_data;
                o_pixel_valid <= 1'b1;
            end else begin
                o_pixel       <= '0;
                o_pixel_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_press_sprite_reader.sv
`timescale 1ns/1ps
// Scoreboard bench for press_sprite_reader: stimulus queues expected address and
// pixel results by due cycle; a negedge monitor pops and compares them.
module tb_press_sprite_reader;
    logic        i_clk2 = 1'b0;
    logic        i_rst = 1'b1;
    logic [9:0]  i_x = '0, i_y = '0;
    logic        i_active = 1'b0, i_frame_tick = 1'b0, i_enable = 1'b0;
    logic [10:0] o_addr;
    logic [7:0]  i_data = '0;
    logic [7:0]  o_pixel;
    logic        o_pixel_valid;

    typedef struct {
        int          due;
        bit          kind;   // 0: address check, 1: pixel check
        logic [10:0] addr;
        logic [7:0]  pix;
        logic        v;
        string       nm;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] pend = '0;
    logic       en = 1'b0;

    press_sprite_reader dut (
        .i_clk2(i_clk2), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_active(i_active),
        .i_frame_tick(i_frame_tick), .i_enable(i_enable), .o_addr(o_addr),
        .i_data(i_data), .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid)
    );

    always #5 i_clk2 = ~i_clk2;
    always @(posedge i_clk2) cyc <= cyc + 1;

    // ROM model: data for the coordinate of the previous cycle arrives now.
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic act,
                         input logic ena, input logic tk, input logic rs,
                         input logic [7:0] dat);
        @(posedge i_clk2);
        #1;
        i_x = x; i_y = y; i_active = act; i_enable = ena;
        i_frame_tick = tk; i_rst = rs;
        i_data = pend;
        pend = dat;
    endtask

    task automatic expect_px(input logic [10:0] a, input logic [7:0] p, input logic v,
                             input string nm);
        q.push_back('{cyc + 1, 1'b0, a, 8'h00, 1'b0, nm});
        q.push_back('{cyc + 2, 1'b1, 11'd0, p, v, nm});
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic act,
                      input logic [7:0] dat, input logic [10:0] a, input logic [7:0] p,
                      input logic v, input string nm);
        drive(x, y, act, en, 1'b0, 1'b0, dat);
        expect_px(a, p, v, nm);
    endtask

    task automatic tick(input int n);
        repeat (n) drive(10'd0, 10'd0, 1'b0, en, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(10'd0, 10'd0, 1'b0, en, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge i_clk2) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.due < cyc) begin
                bad++;
                $display("FAIL %s stale check: due=%0d now=%0d", e.nm, e.due, cyc);
            end else if (!e.kind) begin
                if (o_addr !== e.addr) begin
                    bad++;
                    $display("FAIL %s addr: got %0d want %0d", e.nm, o_addr, e.addr);
                end
            end else if (o_pixel !== e.pix || o_pixel_valid !== e.v) begin
                bad++;
                $display("FAIL %s pixel: got %h/%b want %h/%b", e.nm, o_pixel,
                         o_pixel_valid, e.pix, e.v);
            end
        end
    end

    initial begin
        // Held in reset: in-box opaque pixels must produce nothing.
        drive(10'd236, 10'd400, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
        expect_px(11'd0, 8'h00, 1'b0, "rst_hold0");
        drive(10'd300, 10'd405, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
        expect_px(11'd0, 8'h00, 1'b0, "rst_hold1");

        // Release with enable: first pixel still sees IDLE visibility.
        en = 1'b1;
        px(10'd300, 10'd401, 1'b1, 8'h3C, 11'd232, 8'h00, 1'b0, "first_idle");
        px(10'd236, 10'd400, 1'b1, 8'h3C, 11'd0,    8'h3C, 1'b1, "origin");
        px(10'd403, 10'd411, 1'b1, 8'h55, 11'd2015, 8'h55, 1'b1, "last_px");
        px(10'd404, 10'd400, 1'b1, 8'h55, 11'd0,    8'h00, 1'b0, "right_out");
        px(10'd235, 10'd400, 1'b1, 8'h55, 11'd0,    8'h00, 1'b0, "left_out");
        px(10'd300, 10'd412, 1'b1, 8'h55, 11'd0,    8'h00, 1'b0, "below_out");
        px(10'd300, 10'd401, 1'b1, 8'h00, 11'd232,  8'h00, 1'b0, "transp");
        px(10'd300, 10'd401, 1'b0, 8'h77, 11'd0,    8'h00, 1'b0, "inactive");
        px(10'd403, 10'd405, 1'b1, 8'h11, 11'd1007, 8'h11, 1'b1, "row_end");
        px(10'd236, 10'd406, 1'b1, 8'h12, 11'd1008, 8'h12, 1'b1, "row_wrap");
        px(10'd237, 10'd400, 1'b1, 8'h3C, 11'd1,    8'h3C, 1'b1, "col1");

        // Blink phases of 30 frames.
        tick(29);
        px(10'd237, 10'd400, 1'b1, 8'h3C, 11'd1, 8'h3C, 1'b1, "show_29");
        tick(1);
        px(10'd237, 10'd400, 1'b1, 8'h3C, 11'd1, 8'h00, 1'b0, "hide_30");
        tick(29);
        px(10'd237, 10'd400, 1'b1, 8'h3C, 11'd1, 8'h00, 1'b0, "hide_59");
        tick(1);
        px(10'd237, 10'd400, 1'b1, 8'h3C, 11'd1, 8'h3C, 1'b1, "show_60");

        // Enable drop coinciding with a tick wins; re-enable gets a full phase.
        tick(5);
        en = 1'b0;
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        px(10'd237, 10'd400, 1'b1, 8'h3C, 11'd1, 8'h00, 1'b0, "drop_idle");
        en = 1'b1;
        idle(1);
        px(10'd238, 10'd400, 1'b1, 8'h4D, 11'd2, 8'h4D, 1'b1, "reen_show");
        tick(29);
        px(10'd238, 10'd400, 1'b1, 8'h4D, 11'd2, 8'h4D, 1'b1, "reen_29");
        tick(1);
        px(10'd238, 10'd400, 1'b1, 8'h4D, 11'd2, 8'h00, 1'b0, "reen_30");

        // Mid-row reset during SHOW kills in-flight results immediately.
        tick(30);
        px(10'd239, 10'd400, 1'b1, 8'hA4, 11'd3, 8'hA4, 1'b1, "pre_rst");
        px(10'd240, 10'd400, 1'b1, 8'hA5, 11'd4, 8'h00, 1'b0, "rst_kill_px");
        px(10'd241, 10'd400, 1'b1, 8'hA6, 11'd0, 8'h00, 1'b0, "rst_kill_addr");
        for (int k = 0; k < 3; k++) begin
            drive(10'(242 + k), 10'd400, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA7);
            expect_px(11'd0, 8'h00, 1'b0, "in_rst");
        end
        px(10'd245, 10'd400, 1'b1, 8'hB1, 11'd9,  8'h00, 1'b0, "rel_idle");
        px(10'd246, 10'd400, 1'b1, 8'hB2, 11'd10, 8'hB2, 1'b1, "rel_first_valid");
        idle(4);

        if (q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d checks left unresolved", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
